// File: rtl/branch_flush_ctrl_if.sv
// Pipeline-control bundle between the EX/memory stages and the branch flush
// controller. The pipeline side is the master (branch info, memory stall);
// the controller is the slave (PC / pipeline-register enables and flushes).
interface branch_flush_ctrl_if;
   logic [1:0]  BranchOp;
   logic        AluZero;
   logic        ExValid;
   logic        MemBusy;
   logic        PcWrite;
   logic        PcSel;
   logic        IfIdWrite;
   logic        IfIdFlush;
   logic        IdExFlush;
   logic [15:0] TakenCnt;

   modport master (
      output BranchOp, AluZero, ExValid, MemBusy,
      input  PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExFlush, TakenCnt
   );

   modport slave (
      input  BranchOp, AluZero, ExValid, MemBusy,
      output PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExFlush, TakenCnt
   );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Branch redirect / pipeline flush controller.
// Resolves taken branches in EX, redirects the PC and squashes the wrong-path
// instructions. A redirect that meets a memory stall is parked (PEND) and
// issued once memory is ready; after a redirect the controller keeps bubbling
// ID/EX for FLUSH_CYCLES-1 further progress cycles.
module branch_flush_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   branch_flush_ctrl_if.slave bus
);

   typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

   // A single-cycle flush needs no FLUSH state at all.
   localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
   localparam logic [2:0] FLUSH_LOAD  = MULTI_FLUSH ? 3'(FLUSH_CYCLES - 2) : 3'd0;

   state_t      state, state_nxt;
   logic [2:0]  flush_cnt, flush_cnt_nxt;
   logic [15:0] taken_cnt;
   logic        taken;
   logic        redirect;
   logic        pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Branch resolution: only a real EX instruction can be taken.
   always_comb begin
      taken = 1'b0;
      if (bus.ExValid) begin
         case (bus.BranchOp)
            2'd1:    taken = bus.AluZero;
            2'd2:    taken = !bus.AluZero;
            2'd3:    taken = 1'b1;
            default: taken = 1'b0;
         endcase
      end
   end

   // Next state and Mealy outputs; reset overrides everything at the end.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      redirect      = 1'b0;
      pc_write      = 1'b0;
      pc_sel        = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      case (state)
         RUN: begin
            if (bus.MemBusy) begin
               if (taken) state_nxt = PEND;
            end else if (taken) begin
               redirect = 1'b1;
            end else begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
            end
         end
         PEND: begin
            if (!bus.MemBusy) redirect = 1'b1;
         end
         FLUSH: begin
            id_ex_flush = 1'b1;
            pc_write    = !bus.MemBusy;
            if_id_write = !bus.MemBusy;
            if (!bus.MemBusy) begin
               if (flush_cnt == 3'd0) state_nxt = RUN;
               else                   flush_cnt_nxt = flush_cnt - 3'd1;
            end
         end
         default: state_nxt = RUN;
      endcase
      if (redirect) begin
         pc_write    = 1'b1;
         pc_sel      = 1'b1;
         if_id_write = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         if (MULTI_FLUSH) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
         end else begin
            state_nxt = RUN;
         end
      end
      if (rst) begin
         pc_write    = 1'b0;
         pc_sel      = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   // State, flush counter and saturating redirect counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         flush_cnt <= 3'd0;
         taken_cnt <= 16'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         if (redirect) taken_cnt <= sat_inc(taken_cnt);
      end
   end

   assign bus.PcWrite   = pc_write;
   assign bus.PcSel     = pc_sel;
   assign bus.IfIdWrite = if_id_write;
   assign bus.IfIdFlush = if_id_flush;
   assign bus.IdExFlush = id_ex_flush;
   assign bus.TakenCnt  = taken_cnt;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Testbench for branch_flush_ctrl: three instances (FLUSH_CYCLES = 2, 4, 1)
// share one stimulus stream and are compared every cycle against a
// behavioural model, plus directed table vectors and hand sequences.
`timescale 1ns/1ps
module tb_branch_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] op;
   logic       z, ev, mb;

   always #5 clk = ~clk;

   branch_flush_ctrl_if ifa ();
   branch_flush_ctrl_if ifb ();
   branch_flush_ctrl_if ifc ();

   assign ifa.BranchOp = op;  assign ifa.AluZero = z;  assign ifa.ExValid = ev;  assign ifa.MemBusy = mb;
   assign ifb.BranchOp = op;  assign ifb.AluZero = z;  assign ifb.ExValid = ev;  assign ifb.MemBusy = mb;
   assign ifc.BranchOp = op;  assign ifc.AluZero = z;  assign ifc.ExValid = ev;  assign ifc.MemBusy = mb;

   branch_flush_ctrl #(.FLUSH_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   branch_flush_ctrl #(.FLUSH_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
   branch_flush_ctrl #(.FLUSH_CYCLES(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model: a parked redirect flag, remaining ID/EX bubble cycles
   // still owed, and the redirect count.
   int fc[3] = '{2, 4, 1};
   bit m_pend[3];
   int m_rem[3];
   int m_cnt[3];

   logic [4:0]  smp_out[3];   // {PcWrite, PcSel, IfIdWrite, IfIdFlush, IdExFlush}
   logic [15:0] smp_cnt[3];

   typedef struct {
      bit         r;
      logic [1:0] op;
      bit         z;
      bit         ev;
      bit         mb;
      logic [4:0] eo;
      logic [15:0] ec;
   } vec_t;
   vec_t tab[$];

   function automatic logic [4:0] dut_out(input int k);
      case (k)
         0:       return {ifa.PcWrite, ifa.PcSel, ifa.IfIdWrite, ifa.IfIdFlush, ifa.IdExFlush};
         1:       return {ifb.PcWrite, ifb.PcSel, ifb.IfIdWrite, ifb.IfIdFlush, ifb.IdExFlush};
         default: return {ifc.PcWrite, ifc.PcSel, ifc.IfIdWrite, ifc.IfIdFlush, ifc.IdExFlush};
      endcase
   endfunction

   function automatic logic [15:0] dut_cnt(input int k);
      case (k)
         0:       return ifa.TakenCnt;
         1:       return ifb.TakenCnt;
         default: return ifc.TakenCnt;
      endcase
   endfunction

   function automatic bit is_taken();
      if (!ev) return 1'b0;
      return (op == 2'd3) || (op == 2'd1 && z) || (op == 2'd2 && !z);
   endfunction

   function automatic logic [4:0] model_out(input int k);
      if (rst)                    return 5'b00011;
      if (m_rem[k] > 0)           return {!mb, 1'b0, !mb, 1'b0, 1'b1};
      if (m_pend[k] || is_taken()) return mb ? 5'b00000 : 5'b11111;
      return mb ? 5'b00000 : 5'b10100;
   endfunction

   task automatic model_update();
      bit tk;
      tk = is_taken();
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_pend[k] = 1'b0;
            m_rem[k]  = 0;
            m_cnt[k]  = 0;
         end else if (m_rem[k] > 0) begin
            if (!mb) m_rem[k] = m_rem[k] - 1;
         end else if (m_pend[k] || tk) begin
            if (mb) begin
               m_pend[k] = 1'b1;
            end else begin
               m_pend[k] = 1'b0;
               m_rem[k]  = fc[k] - 1;
               if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_in(input bit r, input logic [1:0] o, input bit zz, input bit e, input bit m);
      rst = r; op = o; z = zz; ev = e; mb = m;
   endtask

   // One clock: sample on the falling edge, compare with the model, advance.
   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         smp_out[k] = dut_out(k);
         smp_cnt[k] = dut_cnt(k);
         if (chk_en) begin
            check($sformatf("model_out_dut%0d", k), 32'(smp_out[k]), 32'(model_out(k)));
            check($sformatf("model_cnt_dut%0d", k), 32'(smp_cnt[k]), 32'(m_cnt[k][15:0]));
         end
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      set_in(1, 2'd0, 0, 0, 0);
      repeat (2) cycle();
      chk_en = 1'b1;

      // Directed vectors; expectations refer to the FLUSH_CYCLES=2 instance.
      tab.push_back('{1, 2'd0, 0, 0, 0, 5'b00011, 16'd0});
      tab.push_back('{0, 2'd1, 1, 1, 0, 5'b11111, 16'd0});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b10101, 16'd1});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b10100, 16'd1});
      tab.push_back('{1, 2'd0, 0, 0, 0, 5'b00011, 16'd1});
      tab.push_back('{0, 2'd2, 1, 1, 0, 5'b10100, 16'd0});
      tab.push_back('{0, 2'd0, 1, 1, 0, 5'b10100, 16'd0});
      tab.push_back('{0, 2'd0, 0, 1, 0, 5'b10100, 16'd0});
      tab.push_back('{0, 2'd3, 0, 0, 0, 5'b10100, 16'd0});
      tab.push_back('{0, 2'd0, 0, 1, 1, 5'b00000, 16'd0});
      tab.push_back('{0, 2'd3, 0, 1, 1, 5'b00000, 16'd0});
      tab.push_back('{0, 2'd3, 0, 1, 1, 5'b00000, 16'd0});
      tab.push_back('{0, 2'd3, 0, 1, 1, 5'b00000, 16'd0});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b11111, 16'd0});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b10101, 16'd1});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b10100, 16'd1});
      tab.push_back('{0, 2'd3, 0, 1, 1, 5'b00000, 16'd1});
      tab.push_back('{1, 2'd3, 0, 1, 1, 5'b00011, 16'd1});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b10100, 16'd0});
      tab.push_back('{0, 2'd0, 0, 0, 0, 5'b10100, 16'd0});
      foreach (tab[i]) begin
         set_in(tab[i].r, tab[i].op, tab[i].z, tab[i].ev, tab[i].mb);
         cycle();
         check($sformatf("tab%0d_out", i), 32'(smp_out[0]), 32'(tab[i].eo));
         check($sformatf("tab%0d_cnt", i), 32'(smp_cnt[0]), 32'(tab[i].ec));
      end

      // Four-cycle flush with two frozen cycles inside FLUSH.
      set_in(1, 2'd0, 0, 0, 0);
      cycle();
      set_in(0, 2'd3, 0, 1, 0);
      cycle();
      check("fc4_redirect", 32'(smp_out[1]), 32'(5'b11111));
      foreach (fc[i]) begin end
      begin
         bit mbs[5] = '{0, 1, 1, 0, 0};
         for (int i = 0; i < 5; i++) begin
            set_in(0, 2'd0, 0, 0, mbs[i]);
            cycle();
            check($sformatf("fc4_idex_flush%0d", i), 32'(smp_out[1][0]), 32'd1);
            check($sformatf("fc4_pcwrite%0d", i), 32'(smp_out[1][4]), 32'(!mbs[i]));
         end
      end
      set_in(0, 2'd0, 0, 0, 0);
      cycle();
      check("fc4_back_to_run", 32'(smp_out[1]), 32'(5'b10100));
      check("fc4_count", 32'(smp_cnt[1]), 32'd1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         cycle();
      end

      // Counter saturation on the single-cycle-flush instance.
      set_in(1, 2'd0, 0, 0, 0);
      cycle();
      set_in(0, 2'd3, 0, 1, 0);
      repeat (65535) cycle();
      cycle();
      check("sat_before", 32'(smp_cnt[2]), 32'hFFFF);
      cycle();
      check("sat_after", 32'(smp_cnt[2]), 32'hFFFF);
      set_in(0, 2'd0, 0, 0, 0);
      cycle();
      check("sat_hold", 32'(smp_cnt[2]), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_flush_ctrl.md
BRANCH_FLUSH_CTRL -- requirements
Module: BRANCH_FLUSH_CTRL

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7: total pipeline-flush cycles per taken redirect.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port BranchOp, input, 2: EX-stage branch type (0 none, 1 beq, 2 bne, 3 jump).
REQ-005 SHALL have port AluZero, input, 1: EX-stage ALU zero flag.
REQ-006 SHALL have port ExValid, input, 1: EX stage holds a real instruction (not a bubble).
REQ-007 SHALL have port MemBusy, input, 1: memory not ready; the pipeline must freeze.
REQ-008 SHALL have port PcWrite, output, 1: PC register load enable.
REQ-009 SHALL have port PcSel, output, 1: 1 = load the branch target, 0 = load PC+4.
REQ-010 SHALL have port IfIdWrite, output, 1: IF/ID register load enable.
REQ-011 SHALL have port IfIdFlush, output, 1: clear IF/ID to a bubble.
REQ-012 SHALL have port IdExFlush, output, 1: clear ID/EX to a bubble.
REQ-013 SHALL have port TakenCnt, output, 16: count of redirects performed.

Function
REQ-014 Taken SHALL be combinational, computed only when ExValid=1:
- 1 for BranchOp=3.
- 1 for BranchOp=1 when AluZero=1.
- 1 for BranchOp=2 when AluZero=0.
- 0 otherwise, and always 0 when ExValid=0.
REQ-015 The FSM SHALL have states RUN, PEND and FLUSH; all outputs SHALL be Mealy functions of state, inputs and rst.
REQ-016 RUN, Taken=0, MemBusy=0: PcWrite=1, PcSel=0, IfIdWrite=1, flushes=0; next state RUN.
REQ-017 RUN, Taken=0, MemBusy=1: PcWrite=0, IfIdWrite=0, flushes=0; next state RUN (freeze).
REQ-018 RUN, Taken=1, MemBusy=0 is a redirect: PcWrite=1, PcSel=1, IfIdFlush=1, IdExFlush=1, TakenCnt+1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-019 RUN, Taken=1, MemBusy=1: PcWrite=0, IfIdWrite=0, no flush, no count; next state PEND.
REQ-020 PEND SHALL ignore BranchOp, AluZero and ExValid.
- MemBusy=1: hold all outputs as in REQ-019.
- MemBusy=0: perform the redirect exactly as in REQ-018, including the next-state rule.
REQ-021 On FLUSH entry, the flush counter SHALL load FLUSH_CYCLES-2.
REQ-022 FLUSH SHALL ignore branch inputs and drive PcWrite=!MemBusy, PcSel=0, IfIdWrite=!MemBusy, IfIdFlush=0, IdExFlush=1.
REQ-023 In FLUSH, the counter SHALL decrement only when MemBusy=0; when it is 0 and MemBusy=0, next state SHALL be RUN.
REQ-024 Each taken branch SHALL be counted exactly once, whether or not it passed through PEND.
REQ-025 TakenCnt SHALL saturate at 16'hFFFF; no wrap-around.
REQ-026 PcSel SHALL never be 1 while PcWrite=0.
REQ-027 A redirect SHALL be issued only in a cycle with MemBusy=0.

Reset
REQ-028 While rst=1, the block SHALL drive PcWrite=0, PcSel=0, IfIdWrite=0, IfIdFlush=1 and IdExFlush=1, regardless of state.
REQ-029 On a clock edge with rst=1, state SHALL become RUN, the flush counter 0 and TakenCnt 0.
REQ-030 Reset asserted in PEND or FLUSH SHALL discard the pending or partial redirect with no count.
REQ-031 The first cycle after rst falls SHALL behave as RUN.

Verification
REQ-032 Reset, then ExValid=1, BranchOp=1, AluZero=1, MemBusy=0, FLUSH_CYCLES=2:
- Cycle 0: PcSel=1, both flushes=1, TakenCnt becomes 1.
- Cycle 1: IdExFlush=1, IfIdFlush=0.
- Cycle 2: RUN outputs.
REQ-033 BranchOp=2 with AluZero=1, then BranchOp=0 with any AluZero, then BranchOp=3 with ExValid=0: no redirect, PcWrite=1, TakenCnt stays 0.
REQ-034 BranchOp=3 with MemBusy=1 held 3 cycles:
- PcWrite=0 for all 3 cycles, state PEND, no count.
- Cycle 4, MemBusy=0 (branch inputs changed to 0): redirect, TakenCnt +1 exactly once.
REQ-035 FLUSH_CYCLES=4, redirect followed by MemBusy=1 for 2 cycles inside FLUSH: IdExFlush stays 1 for the 3 progress cycles plus the 2 frozen cycles, then RUN.
REQ-036 Force 65535 redirects, then one more: TakenCnt=16'hFFFF both before and after.
REQ-037 Assert rst while in PEND:
- During rst: PcWrite=0, both flushes=1.
- After rst: RUN, TakenCnt=0, no late redirect when MemBusy drops.
